// File: rtl/byte_word_assembler.sv
// Byte-serial to word assembler. Collects bytes LSB-first into a WIDTH-bit
// word, then holds it stable under a valid/ready handshake until the
// downstream shift-register stage takes it. A flush closes a partial word
// early, leaving the unfilled upper bytes at zero.
module byte_word_assembler #(
    parameter  int WIDTH  = 128,               // must be a multiple of 8
    localparam int NBYTES = WIDTH / 8,
    localparam int CW     = $clog2(NBYTES) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CW-1:0]    byte_count
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last_byte;
    logic             close_word;
    logic [WIDTH-1:0] word_d;

    assign accept     = in_valid && in_ready;
    assign last_byte  = (byte_count == CW'(NBYTES - 1));
    // A flush closes the word only if it will contain at least one byte,
    // counting a byte accepted on the same edge.
    assign close_word = (accept && last_byte) ||
                        (flush && (accept || (byte_count != '0)));

    // State register: reset lands in FILL, ready to take the first byte.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: FILL closes on the last byte or a non-empty flush,
    // HOLD releases once the consumer takes the word.
    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            FILL: if (close_word) state_d = HOLD;
            HOLD: if (word_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Output logic: handshake flags decode directly from the state; ready is
    // also gated by reset so nothing is taken while reset is asserted.
    always_comb begin
        in_ready   = (state_q == FILL) && !reset;
        word_valid = (state_q == HOLD);
    end

    // Byte lane steering: the incoming byte replaces the lane selected by the
    // current byte count; all other lanes keep their contents.
    always_comb begin
        word_d = word;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_count == CW'(i)) begin
                word_d[8*i +: 8] = in_data;
            end
        end
    end

    // Word and byte count: cleared on handoff so a later flush leaves zeros
    // in unfilled lanes; filled one byte per accepted transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word       <= '0;
            byte_count <= '0;
        end else if ((state_q == HOLD) && word_ready) begin
            word       <= '0;
            byte_count <= '0;
        end else if (accept) begin
            word       <= word_d;
            byte_count <= byte_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_byte_word_assembler.sv
// Self-checking bench for byte_word_assembler. A reference model keeps the
// current word as a queue of bytes plus a held flag and is compared against
// the DUT one time unit after every rising edge.
module tb_byte_word_assembler;

    localparam int WIDTH  = 128;
    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = $clog2(NBYTES) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic [CW-1:0]    byte_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bytes collected so far, and whether the word is held.
    logic [7:0] m_bytes[$];
    bit         m_hold = 1'b0;

    byte_word_assembler #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_count (byte_count)
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] m_word();
        logic [WIDTH-1:0] w = '0;
        foreach (m_bytes[i]) w |= WIDTH'(m_bytes[i]) << (8 * i);
        return w;
    endfunction

    function automatic logic [CW-1:0] m_count();
        return CW'(m_bytes.size());
    endfunction

    // Drive one cycle of inputs, advance the model across the rising edge and
    // leave time 1 unit after the edge for sampling.
    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
        in_valid   = v;
        in_data    = d;
        flush      = f;
        word_ready = r;
        @(posedge clock);
        if (m_hold) begin
            if (r) begin
                m_bytes.delete();
                m_hold = 1'b0;
            end
        end else begin
            if (v) m_bytes.push_back(d);
            if (m_bytes.size() == NBYTES || (f && m_bytes.size() > 0)) m_hold = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        word_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 reset = 1'b1;
        #2;
        vectors++;
        if ({word_valid, in_ready, byte_count, word} !== {1'b0, 1'b0, CW'(0), WIDTH'(0)}) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b rdy=%b cnt=%0d word=%h, expected v=0 rdy=0 cnt=0 word=0",
                     word_valid, in_ready, byte_count, word);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_bytes.delete();
        m_hold = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_full_word();
        for (int i = 0; i < NBYTES; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b1);
            vectors++;
            if ({word_valid, in_ready, byte_count, word} !== {m_hold, ~m_hold, m_count(), m_word()}) begin
                miscompares++;
                $display("FAIL full_word[%0d]: got v=%b rdy=%b cnt=%0d word=%h, expected v=%b rdy=%b cnt=%0d word=%h",
                         i, word_valid, in_ready, byte_count, word, m_hold, ~m_hold, m_count(), m_word());
            end
        end
        vectors++;
        if ({word_valid, byte_count, word} !== {1'b1, CW'(16), 128'h0F0E0D0C0B0A09080706050403020100}) begin
            miscompares++;
            $display("FAIL full_word_const: got v=%b cnt=%0d word=%h, expected v=1 cnt=16 word=0f0e0d0c0b0a09080706050403020100",
                     word_valid, byte_count, word);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if ({word_valid, in_ready, byte_count, word} !== {1'b0, 1'b1, CW'(0), WIDTH'(0)}) begin
            miscompares++;
            $display("FAIL full_word_release: got v=%b rdy=%b cnt=%0d word=%h, expected v=0 rdy=1 cnt=0 word=0",
                     word_valid, in_ready, byte_count, word);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if ({word_valid, in_ready, byte_count, word} !== {1'b1, 1'b0, CW'(3), WIDTH'(32'h00CCBBAA)}) begin
            miscompares++;
            $display("FAIL flush_partial: got v=%b rdy=%b cnt=%0d word=%h, expected v=1 rdy=0 cnt=3 word=ccbbaa",
                     word_valid, in_ready, byte_count, word);
        end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        vectors++;
        if ({word_valid, byte_count, word} !== {m_hold, m_count(), m_word()}) begin
            miscompares++;
            $display("FAIL flush_release: got v=%b cnt=%0d word=%h, expected v=%b cnt=%0d word=%h",
                     word_valid, byte_count, word, m_hold, m_count(), m_word());
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held;
        for (int i = 0; i < NBYTES; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        held = m_word();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h55, 1'b0, 1'b0);
            vectors++;
            if ({word_valid, in_ready, byte_count, word} !== {1'b1, 1'b0, CW'(16), held}) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: got v=%b rdy=%b cnt=%0d word=%h, expected v=1 rdy=0 cnt=16 word=%h",
                         i, word_valid, in_ready, byte_count, word, held);
            end
        end
        step(1'b1, 8'h55, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        vectors++;
        if ({word_valid, byte_count, word} !== {1'b0, CW'(1), WIDTH'(8'h55)}) begin
            miscompares++;
            $display("FAIL backpressure_resume: got v=%b cnt=%0d word=%h, expected v=0 cnt=1 word=55",
                     word_valid, byte_count, word);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({word_valid, in_ready, byte_count, word} !== {1'b0, 1'b0, CW'(0), WIDTH'(0)}) begin
            miscompares++;
            $display("FAIL reset_mid_fill: got v=%b rdy=%b cnt=%0d word=%h, expected v=0 rdy=0 cnt=0 word=0",
                     word_valid, in_ready, byte_count, word);
        end
        #1 reset = 1'b0;
        m_bytes.delete();
        m_hold = 1'b0;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        vectors++;
        if ({word_valid, byte_count, word} !== {1'b0, CW'(1), WIDTH'(8'h11)}) begin
            miscompares++;
            $display("FAIL reset_refill: got v=%b cnt=%0d word=%h, expected v=0 cnt=1 word=11",
                     word_valid, byte_count, word);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_flush_corners();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if ({word_valid, in_ready, byte_count} !== {1'b0, 1'b1, CW'(0)}) begin
            miscompares++;
            $display("FAIL flush_empty: got v=%b rdy=%b cnt=%0d, expected v=0 rdy=1 cnt=0",
                     word_valid, in_ready, byte_count);
        end
        for (int i = 0; i < NBYTES - 1; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        vectors++;
        if ({word_valid, byte_count, word[127:120]} !== {1'b1, CW'(16), 8'hFF} || word !== m_word()) begin
            miscompares++;
            $display("FAIL flush_with_last: got v=%b cnt=%0d word=%h, expected v=1 cnt=16 word=%h",
                     word_valid, byte_count, word, m_word());
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if ({word_valid, in_ready, byte_count} !== {1'b0, 1'b1, CW'(0)}) begin
            miscompares++;
            $display("FAIL flush_no_extra_word: got v=%b rdy=%b cnt=%0d, expected v=0 rdy=1 cnt=0",
                     word_valid, in_ready, byte_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'b1 && ($urandom_range(3) != 0), 8'($urandom),
                 $urandom_range(7) == 0, 1'($urandom));
            vectors++;
            if ({word_valid, in_ready, byte_count, word} !== {m_hold, ~m_hold, m_count(), m_word()}) begin
                miscompares++;
                $display("FAIL random[%0d]: got v=%b rdy=%b cnt=%0d word=%h, expected v=%b rdy=%b cnt=%0d word=%h",
                         i, word_valid, in_ready, byte_count, word, m_hold, ~m_hold, m_count(), m_word());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_backpressure();
        test_reset_mid_fill();
        test_flush_corners();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/byte_word_assembler.md
Name: byte_word_assembler

Overview:
- Assembles a byte-serial input stream into one WIDTH-bit word.
- Presents that word to the downstream 128-bit cyclic right-shift register stage as its parallel data input D.
- Valid/ready handshake on both sides; holds the word stable until the consumer takes it.
- Supports a flush that releases a partially filled word, zero-padded in the unfilled upper bytes.

Parameters:
- WIDTH, 128, output word width in bits; must be a multiple of 8.
- NBYTES, WIDTH/8, bytes per word; derived, not overridden.
- CW, $clog2(NBYTES)+1, width of byte_count (5 for default).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  assembler accepts a byte this cycle.
- flush  input  1  close the current partial word early.
- word  output  WIDTH  assembled word; drives downstream D.
- word_valid  output  1  word is complete and stable.
- word_ready  input  1  downstream consumes word this cycle.
- byte_count  output  CW  bytes written into the current word.

Behaviour:
- Reset (asynchronous, takes effect immediately on assertion):
  - state=FILL, word=0, byte_count=0, word_valid=0.
  - in_ready forced 0 while reset is high; returns to 1 on the first cycle after release.
- States: FILL, HOLD.
  - in_ready=1 only in FILL (and not in reset).
  - word_valid=1 only in HOLD.
- Byte placement: byte accepted with byte_count=k is written to word[8k+7:8k]; the first byte lands in the LSB.
- Accept in FILL: in_valid && in_ready. On accept, byte_count increments.
- FILL -> HOLD when either:
  - a byte is accepted at byte_count=NBYTES-1 (byte_count becomes NBYTES); or
  - flush=1 with byte_count>0 after any same-cycle byte is applied.
- flush with byte_count=0 and no same-cycle accept: ignored, remains in FILL.
- flush and accept in the same cycle: byte written first, then transition to HOLD. This produces a single word, never two.
- Zero padding: unfilled bytes are 0, guaranteed by clearing word on each handoff.
- HOLD:
  - word, byte_count and word_valid are frozen; in_data is ignored and flush has no effect.
  - word_ready=1: next edge clears word to 0, sets byte_count=0 and returns to FILL.
  - No same-cycle refill; a byte presented on that edge is not accepted because in_ready=0.
- Latency and throughput:
  - word_valid rises on the clock edge that accepts the final byte, i.e. 0 extra cycles.
  - Maximum throughput is one word per NBYTES+1 cycles.
- Downstream timing: word changes only on rising edges, so it is stable at the falling edge where the shift register samples. Downstream captures D on any negedge while word_valid=1.
- word_ready while word_valid=0: ignored.
- byte_count in HOLD holds the number of valid bytes (1..NBYTES).
- Reset mid-FILL or mid-HOLD discards the partial or held word. No output glitches beyond the asynchronous clear.

Test Plan:
- Full word: bytes 0x00..0x0F, one per cycle, word_ready=1.
  -> word_valid rises on the 16th accept edge.
  -> word=0x0F0E0D0C0B0A09080706050403020100, byte_count=16.
  -> Next edge: FILL, word=0.
- Flush: bytes 0xAA, 0xBB, 0xCC, then flush=1.
  -> HOLD with word=0x...00CCBBAA (upper 13 bytes zero), byte_count=3.
- Backpressure: full word completes, word_ready=0 for 5 cycles, in_valid held high with 0x55.
  -> in_ready=0, word unchanged for all 5 cycles.
  -> After word_ready=1 the next word starts with 0x55 at bits [7:0]; no byte lost or duplicated.
- Reset mid-fill: 7 bytes accepted, reset pulsed between clock edges.
  -> word=0, byte_count=0, word_valid=0 immediately.
  -> After release, next byte 0x11 lands in bits [7:0].
- Flush corners:
  -> flush with byte_count=0 stays in FILL with word_valid=0.
  -> flush together with the 16th byte (0xFF) gives one word with byte_count=16, word[127:120]=0xFF, and no extra empty word.
